// File: rtl/switch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_pkg: shared switch width and debounce defaults              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package switch_pkg;

  localparam int SW_WIDTH                   = 24;
  localparam int DEB_SAMPLE_DIV_DEFAULT     = 100000;
  localparam int DEB_STABLE_SAMPLES_DEFAULT = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | debounce_bit: stability counter and debounced output for one bit   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module debounce_bit
  import switch_pkg::*;
#(
  parameter int STABLE_SAMPLES = DEB_STABLE_SAMPLES_DEFAULT
) (
  input  logic switclk,
  input  logic switrst,
  input  logic tick,
  input  logic s2_bit,
  output logic stable_o,
  output logic pulse_o
);

  localparam int               CNT_W    = cnt_width(STABLE_SAMPLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             pulse_q, pulse_d;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    pulse_d  = 1'b0;
    if (tick) begin
      if (s2_bit == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = s2_bit;
        cnt_d    = '0;
        pulse_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge switclk) begin
    if (!switrst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      pulse_q  <= pulse_d;
    end
  end

  assign stable_o = stable_q;
  assign pulse_o  = pulse_q;

endmodule
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | switch_debounce: sync + debounce of DIP switches with change flag  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module switch_debounce
  import switch_pkg::*;
#(
  parameter int WIDTH          = SW_WIDTH,
  parameter int SAMPLE_DIV     = DEB_SAMPLE_DIV_DEFAULT,
  parameter int STABLE_SAMPLES = DEB_STABLE_SAMPLES_DEFAULT
) (
  input  logic             switclk,
  input  logic             switrst,
  input  logic [WIDTH-1:0] switch_raw,
  input  logic             flag_clr,
  output logic [WIDTH-1:0] switch_o,
  output logic [WIDTH-1:0] change_pulse,
  output logic             change_flag
);

  localparam int                 PRESC_W    = cnt_width(SAMPLE_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(SAMPLE_DIV - 1);

  logic [WIDTH-1:0]   s1_q, s2_q;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               flag_q, flag_d;
  logic               tick;
  logic [WIDTH-1:0]   stable_vec;
  logic [WIDTH-1:0]   pulse_vec;

  assign tick = (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q + 1'b1;
    if (tick) begin
      presc_d = '0;
    end
  end

  // A fresh pulse outranks a clear so that no change event is lost.
  always_comb begin
    flag_d = flag_q;
    if (|pulse_vec) begin
      flag_d = 1'b1;
    end else if (flag_clr) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge switclk) begin
    if (!switrst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      presc_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      s1_q    <= switch_raw;
      s2_q    <= s1_q;
      presc_q <= presc_d;
      flag_q  <= flag_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_bit (
      .switclk (switclk),
      .switrst (switrst),
      .tick    (tick),
      .s2_bit  (s2_q[i]),
      .stable_o(stable_vec[i]),
      .pulse_o (pulse_vec[i])
    );
  end

  assign switch_o     = stable_vec;
  assign change_pulse = pulse_vec;
  assign change_flag  = flag_q;

endmodule
`default_nettype wire

// File: tb/tb_switch_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_switch_debounce: directed and random checks vs a history model  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_switch_debounce;

  localparam int W      = 24;
  localparam int DIV_A  = 1;
  localparam int STAB_A = 4;
  localparam int DIV_B  = 4;
  localparam int STAB_B = 2;

  logic         switclk = 1'b0;
  logic         rstn_a, rstn_b, clr_a, clr_b;
  logic [W-1:0] raw_a, raw_b;
  logic [W-1:0] sw_a, pulse_a, sw_b, pulse_b;
  logic         flag_a, flag_b;

  int checks = 0;
  int errors = 0;

  always #5 switclk = ~switclk;

  switch_debounce #(.WIDTH(W), .SAMPLE_DIV(DIV_A), .STABLE_SAMPLES(STAB_A)) dut_a (
    .switclk(switclk), .switrst(rstn_a), .switch_raw(raw_a), .flag_clr(clr_a),
    .switch_o(sw_a), .change_pulse(pulse_a), .change_flag(flag_a)
  );

  switch_debounce #(.WIDTH(W), .SAMPLE_DIV(DIV_B), .STABLE_SAMPLES(STAB_B)) dut_b (
    .switclk(switclk), .switrst(rstn_b), .switch_raw(raw_b), .flag_clr(clr_b),
    .switch_o(sw_b), .change_pulse(pulse_b), .change_flag(flag_b)
  );

  // Reference model: each bit keeps a history of the synchronised samples
  // taken on ticks; it flips once the most recent STABLE samples taken since
  // its last flip (or reset) all disagree with the current output.
  logic [W-1:0] m_s1[2], m_s2[2], m_out[2], m_pulse[2];
  logic         m_flag[2];
  int           m_cyc[2];
  logic [7:0]   m_hist[2][W];
  int           m_nval[2][W];

  task automatic model_step(input int i, input int div, input int stab,
                            input logic rstn, input logic [W-1:0] raw, input logic clr);
    logic [W-1:0] nout, npulse;
    logic [7:0]   mask;
    logic         tk;
    if (!rstn) begin
      m_s1[i] = '0; m_s2[i] = '0; m_out[i] = '0; m_pulse[i] = '0;
      m_flag[i] = 1'b0; m_cyc[i] = 0;
      for (int b = 0; b < W; b++) begin
        m_hist[i][b] = '0;
        m_nval[i][b] = 0;
      end
    end else begin
      tk = ((m_cyc[i] % div) == div - 1);
      m_cyc[i]++;
      if (|m_pulse[i]) m_flag[i] = 1'b1;
      else if (clr)    m_flag[i] = 1'b0;
      nout   = m_out[i];
      npulse = '0;
      mask   = 8'((1 << stab) - 1);
      if (tk) begin
        for (int b = 0; b < W; b++) begin
          m_hist[i][b] = {m_hist[i][b][6:0], m_s2[i][b]};
          m_nval[i][b]++;
          if (m_nval[i][b] >= stab &&
              ((m_hist[i][b] ^ {8{~m_out[i][b]}}) & mask) == 8'h00) begin
            nout[b]      = ~m_out[i][b];
            npulse[b]    = 1'b1;
            m_nval[i][b] = 0;
          end
        end
      end
      m_out[i]   = nout;
      m_pulse[i] = npulse;
      m_s2[i]    = m_s1[i];
      m_s1[i]    = raw;
    end
  endtask

  always @(posedge switclk) begin
    model_step(0, DIV_A, STAB_A, rstn_a, raw_a, clr_a);
    model_step(1, DIV_B, STAB_B, rstn_b, raw_b, clr_b);
  end

  task automatic test_reset();
    logic [W-1:0] exp_sw, exp_p;
    logic         exp_f;
    rstn_a = 1'b0; raw_a = '1; clr_a = 1'b0;
    repeat (3) begin
      @(negedge switclk);
      checks++;
      if ({sw_a, pulse_a, flag_a} !== '0) begin
        errors++;
        $display("FAIL reset_hold: sw=%h pulse=%h flag=%b, expected all 0", sw_a, pulse_a, flag_a);
      end
    end
    rstn_a = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge switclk);
      exp_sw = (c >= 6) ? '1 : '0;
      exp_p  = (c == 6) ? '1 : '0;
      exp_f  = (c >= 7);
      checks++;
      if (sw_a !== exp_sw || pulse_a !== exp_p || flag_a !== exp_f) begin
        errors++;
        $display("FAIL first_qualify c=%0d: sw=%h pulse=%h flag=%b, expected sw=%h pulse=%h flag=%b",
                 c, sw_a, pulse_a, flag_a, exp_sw, exp_p, exp_f);
      end
      checks++;
      if (sw_a !== m_out[0] || pulse_a !== m_pulse[0] || flag_a !== m_flag[0]) begin
        errors++;
        $display("FAIL reset_model c=%0d: sw=%h pulse=%h flag=%b, model sw=%h pulse=%h flag=%b",
                 c, sw_a, pulse_a, flag_a, m_out[0], m_pulse[0], m_flag[0]);
      end
    end
  endtask

  task automatic test_glitch();
    raw_a = '0; rstn_a = 1'b0;
    @(negedge switclk);
    rstn_a = 1'b1;
    repeat (4) @(negedge switclk);
    raw_a = 24'h000008;
    for (int c = 1; c <= 16; c++) begin
      @(negedge switclk);
      checks++;
      if (sw_a !== '0 || pulse_a !== '0 || flag_a !== 1'b0) begin
        errors++;
        $display("FAIL glitch c=%0d: sw=%h pulse=%h flag=%b, expected all 0", c, sw_a, pulse_a, flag_a);
      end
      checks++;
      if (sw_a !== m_out[0] || pulse_a !== m_pulse[0] || flag_a !== m_flag[0]) begin
        errors++;
        $display("FAIL glitch_model c=%0d: sw=%h pulse=%h flag=%b, model sw=%h pulse=%h flag=%b",
                 c, sw_a, pulse_a, flag_a, m_out[0], m_pulse[0], m_flag[0]);
      end
      if (c == 3) raw_a = '0;
    end
  endtask

  task automatic test_multi_bit();
    logic [W-1:0] exp_sw, exp_p;
    logic         exp_f;
    raw_a = 24'h800001;
    for (int c = 1; c <= 12; c++) begin
      @(negedge switclk);
      exp_sw = (c >= 6) ? 24'h800001 : 24'h000000;
      exp_p  = (c == 6) ? 24'h800001 : 24'h000000;
      exp_f  = (c == 7);
      checks++;
      if (sw_a !== exp_sw || pulse_a !== exp_p || flag_a !== exp_f) begin
        errors++;
        $display("FAIL multi_bit c=%0d: sw=%h pulse=%h flag=%b, expected sw=%h pulse=%h flag=%b",
                 c, sw_a, pulse_a, flag_a, exp_sw, exp_p, exp_f);
      end
      if (c == 7) clr_a = 1'b1;
      if (c == 8) clr_a = 1'b0;
    end
  endtask

  task automatic test_clr_collision();
    logic [W-1:0] exp_sw, exp_p;
    logic         exp_f;
    raw_a = 24'h800021;
    for (int c = 1; c <= 10; c++) begin
      @(negedge switclk);
      exp_sw = (c >= 6) ? 24'h800021 : 24'h800001;
      exp_p  = (c == 6) ? 24'h000020 : 24'h000000;
      exp_f  = (c >= 7);
      checks++;
      if (sw_a !== exp_sw || pulse_a !== exp_p || flag_a !== exp_f) begin
        errors++;
        $display("FAIL clr_collision c=%0d: sw=%h pulse=%h flag=%b, expected sw=%h pulse=%h flag=%b",
                 c, sw_a, pulse_a, flag_a, exp_sw, exp_p, exp_f);
      end
      if (c == 6) clr_a = 1'b1;
      if (c == 7) clr_a = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] exp_sw, exp_p;
    logic         exp_f;
    raw_a = 24'h00F0F0;
    repeat (10) @(negedge switclk);
    checks++;
    if (sw_a !== 24'h00F0F0) begin
      errors++;
      $display("FAIL pre_reset_value: sw=%h, expected 00f0f0", sw_a);
    end
    rstn_a = 1'b0;
    @(negedge switclk);
    checks++;
    if (sw_a !== '0 || pulse_a !== '0 || flag_a !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: sw=%h pulse=%h flag=%b, expected all 0", sw_a, pulse_a, flag_a);
    end
    rstn_a = 1'b1;
    for (int c = 2; c <= 12; c++) begin
      @(negedge switclk);
      exp_sw = (c >= 7) ? 24'h00F0F0 : 24'h000000;
      exp_p  = (c == 7) ? 24'h00F0F0 : 24'h000000;
      exp_f  = (c >= 8);
      checks++;
      if (sw_a !== exp_sw || pulse_a !== exp_p || flag_a !== exp_f) begin
        errors++;
        $display("FAIL requalify c=%0d: sw=%h pulse=%h flag=%b, expected sw=%h pulse=%h flag=%b",
                 c, sw_a, pulse_a, flag_a, exp_sw, exp_p, exp_f);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge switclk);
      checks++;
      if (sw_a !== m_out[0] || pulse_a !== m_pulse[0] || flag_a !== m_flag[0]) begin
        errors++;
        $display("FAIL random c=%0d: sw=%h pulse=%h flag=%b, model sw=%h pulse=%h flag=%b",
                 c, sw_a, pulse_a, flag_a, m_out[0], m_pulse[0], m_flag[0]);
      end
      if ($urandom_range(3) == 0) raw_a = raw_a ^ W'($urandom & $urandom & $urandom);
      clr_a  = ($urandom_range(15) == 0);
      rstn_a = ($urandom_range(199) != 0);
    end
    rstn_a = 1'b1;
    clr_a  = 1'b0;
  endtask

  task automatic test_slow_tick();
    logic [W-1:0] exp_sw;
    logic         exp_f;
    rstn_b = 1'b0; raw_b = '0; clr_b = 1'b0;
    repeat (2) @(negedge switclk);
    rstn_b = 1'b1;
    raw_b  = 24'h000001;
    for (int c = 1; c <= 24; c++) begin
      @(negedge switclk);
      exp_sw = (c >= 8) ? 24'h000001 : 24'h000000;
      exp_f  = (c >= 9);
      checks++;
      if (sw_b !== exp_sw || pulse_b !== ((c == 8) ? 24'h000001 : 24'h000000) || flag_b !== exp_f) begin
        errors++;
        $display("FAIL slow_tick c=%0d: sw=%h pulse=%h flag=%b, expected sw=%h flag=%b pulse on c=8 only",
                 c, sw_b, pulse_b, flag_b, exp_sw, exp_f);
      end
      checks++;
      if (sw_b !== m_out[1] || pulse_b !== m_pulse[1] || flag_b !== m_flag[1]) begin
        errors++;
        $display("FAIL slow_model c=%0d: sw=%h pulse=%h flag=%b, model sw=%h pulse=%h flag=%b",
                 c, sw_b, pulse_b, flag_b, m_out[1], m_pulse[1], m_flag[1]);
      end
      if (c == 10) raw_b = 24'h000000;
      if (c == 13) raw_b = 24'h000001;
    end
  endtask

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0;
    clr_a  = 1'b0; clr_b  = 1'b0;
    raw_a  = '0;   raw_b  = '0;
    test_reset();
    test_glitch();
    test_multi_bit();
    test_clr_collision();
    test_reset_mid();
    test_random();
    test_slow_tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
